ladybird_fetch_queue: RTL and testbench

- Parametrised instruction prefetch unit placed between the core front-end and the MMU instruction port.
- Replaces single-in-flight fetch, where a new PC is sent only after the previous instruction commits, with sequential prefetch.
- Keeps up to DEPTH requests outstanding or buffered, tags each returned instruction with its PC, and delivers it in order through a valid/ready port.
- On redirect (branch, jump, trap, start), flushes buffered entries and drops stale in-flight responses.

---
 rtl/ladybird_fetch_queue.sv | 108 ++++++++++
 tb/tb_ladybird_fetch_queue.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/ladybird_fetch_queue.sv
// Sequential instruction prefetcher: issues PCs to the MMU under a DEPTH credit limit,
// tags responses with their PC and delivers them in order; redirect flushes and drops stale replies.
module ladybird_fetch_queue #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            halt,
  output logic [XLEN-1:0] pc,
  output logic            pc_valid,
  input  logic            pc_ready,
  input  logic [XLEN-1:0] inst,
  input  logic            inst_valid,
  output logic            o_valid,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_inst,
  input  logic            o_ready,
  output logic            idle
);

  localparam int AW = $clog2(DEPTH);

  logic            running;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] resp_pc;
  logic [CNT_W-1:0] outstanding;
  logic [CNT_W-1:0] discard;
  logic [CNT_W-1:0] count;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [XLEN-1:0]  mem_pc   [DEPTH];
  logic [XLEN-1:0]  mem_inst [DEPTH];

  logic [CNT_W:0] credit_used;
  logic           accept;
  logic           drop;
  logic           push;
  logic           pop;
  logic [XLEN-1:0] target_pc;

  // Buffered entries plus in-flight requests never exceed DEPTH, so every response has a slot.
  assign credit_used = {1'b0, outstanding} + {1'b0, count};
  assign pc_valid    = running & ~redirect_valid & ~halt & (credit_used < (CNT_W+1)'(DEPTH));
  assign pc          = fetch_pc;
  assign accept      = pc_valid & pc_ready;
  assign drop        = inst_valid & (discard != '0);
  assign push        = inst_valid & (discard == '0) & ~redirect_valid;
  assign pop         = o_valid & o_ready & ~redirect_valid;
  assign target_pc   = {redirect_pc[XLEN-1:2], 2'b00};

  assign o_valid = (count != '0);
  assign o_pc    = mem_pc[rd_ptr];
  assign o_inst  = mem_inst[rd_ptr];
  assign idle    = (outstanding == '0) & (discard == '0) & (count == '0);

  always_ff @(posedge clk) begin
    if (!nrst) begin
      running     <= 1'b0;
      fetch_pc    <= '0;
      resp_pc     <= '0;
      outstanding <= '0;
      discard     <= '0;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_pc[i]   <= '0;
        mem_inst[i] <= '0;
      end
    end else if (redirect_valid) begin
      // Every request still unanswered after this cycle belongs to the old stream.
      running     <= 1'b1;
      fetch_pc    <= target_pc;
      resp_pc     <= target_pc;
      outstanding <= outstanding - CNT_W'(inst_valid);
      discard     <= outstanding - CNT_W'(inst_valid);
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else begin
      if (halt) begin
        running <= 1'b0;
      end
      if (accept) begin
        fetch_pc <= fetch_pc + XLEN'(4);
      end
      outstanding <= outstanding + CNT_W'(accept) - CNT_W'(inst_valid);
      if (drop) begin
        discard <= discard - CNT_W'(1);
      end
      if (push) begin
        mem_pc[wr_ptr]   <= resp_pc;
        mem_inst[wr_ptr] <= inst;
        wr_ptr           <= wr_ptr + AW'(1);
        resp_pc          <= resp_pc + XLEN'(4);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

endmodule

// File: tb/tb_ladybird_fetch_queue.sv
// Randomized bench for ladybird_fetch_queue: an in-order MMU model with random latency and an
// epoch-tagged reference queue predict pc, pc_valid, head entry and idle every cycle.
module tb_ladybird_fetch_queue;
  localparam int XLEN  = 32;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            nrst;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            halt;
  logic [XLEN-1:0] pc;
  logic            pc_valid;
  logic            pc_ready;
  logic [XLEN-1:0] inst;
  logic            inst_valid;
  logic            o_valid;
  logic [XLEN-1:0] o_pc;
  logic [XLEN-1:0] o_inst;
  logic            o_ready;
  logic            idle;

  always #5 clk = ~clk;

  ladybird_fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .nrst(nrst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt),
    .pc(pc), .pc_valid(pc_valid), .pc_ready(pc_ready),
    .inst(inst), .inst_valid(inst_valid),
    .o_valid(o_valid), .o_pc(o_pc), .o_inst(o_inst), .o_ready(o_ready),
    .idle(idle)
  );

  typedef struct { logic [XLEN-1:0] pc; int ep; } req_t;
  typedef struct { logic [XLEN-1:0] pc; logic [XLEN-1:0] inst; } ent_t;

  req_t mmu_q[$];   // accepted requests awaiting a response, with the fetch stream they belong to
  ent_t exp_q[$];   // instructions the consumer should see, in order
  bit              run_m;
  logic [XLEN-1:0] next_pc_m;
  int              epoch;
  int checks = 0;
  int errors = 0;
  int obs_acc;
  int pops;

  function automatic logic [XLEN-1:0] mem_word(logic [XLEN-1:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(string tag, logic [XLEN-1:0] got, logic [XLEN-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    nrst = 1'b0; redirect_valid = 1'b0; halt = 1'b0; pc_ready = 1'b0;
    o_ready = 1'b0; inst_valid = 1'b0; redirect_pc = '0; inst = '0;
    @(posedge clk);
    #1;
    mmu_q.delete();
    exp_q.delete();
    run_m = 1'b0;
    next_pc_m = '0;
    check("rst_o_pc", o_pc, '0);
    check("rst_o_inst", o_inst, '0);
    check("rst_o_valid", o_valid, 1'b0);
    check("rst_pc_valid", pc_valid, 1'b0);
    check("rst_pc", pc, '0);
    check("rst_idle", idle, 1'b1);
  endtask

  // One clock cycle: drive inputs, compare DUT against the model, then advance the model.
  task automatic step(bit rv, logic [XLEN-1:0] rpc, bit h, bit pr, bit orr, bit rsp);
    bit   exp_pv;
    bit   resp;
    req_t r;
    ent_t e;
    @(negedge clk);
    nrst = 1'b1; redirect_valid = rv; redirect_pc = rpc; halt = h;
    pc_ready = pr; o_ready = orr;
    resp = rsp && (mmu_q.size() > 0);
    inst_valid = resp;
    inst = resp ? mem_word(mmu_q[0].pc) : $urandom;
    #1;
    exp_pv = run_m && !rv && !h && (mmu_q.size() + exp_q.size() < DEPTH);
    check("pc_valid", pc_valid, exp_pv);
    check("pc", pc, next_pc_m);
    check("o_valid", o_valid, exp_q.size() != 0);
    check("idle", idle, (mmu_q.size() == 0) && (exp_q.size() == 0));
    if (exp_q.size() != 0) begin
      check("o_pc", o_pc, exp_q[0].pc);
      check("o_inst", o_inst, exp_q[0].inst);
    end
    if (pc_valid && pr) obs_acc++;
    if (o_valid && orr && !rv) pops++;

    if (!rv && orr && exp_q.size() != 0) void'(exp_q.pop_front());
    if (resp) begin
      r = mmu_q.pop_front();
      if (!rv && r.ep == epoch) begin
        e.pc = r.pc;
        e.inst = mem_word(r.pc);
        exp_q.push_back(e);
      end
    end
    if (rv) begin
      exp_q.delete();
      epoch++;
      run_m = 1'b1;
      next_pc_m = {rpc[XLEN-1:2], 2'b00};
    end else begin
      if (exp_pv && pr) begin
        r.pc = next_pc_m;
        r.ep = epoch;
        mmu_q.push_back(r);
        next_pc_m = next_pc_m + 32'd4;
      end
      if (h) run_m = 1'b0;
    end
  endtask

  initial begin
    logic [XLEN-1:0] rpc;
    nrst = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; halt = 1'b0;
    pc_ready = 1'b0; inst = '0; inst_valid = 1'b0; o_ready = 1'b0;
    epoch = 0; run_m = 1'b0; next_pc_m = '0; obs_acc = 0; pops = 0;
    repeat (2) @(posedge clk);
    do_reset();

    // Streaming at one instruction per cycle once the pipeline fills.
    step(1, 32'h8000_0000, 0, 1, 1, 1);
    repeat (4) step(0, '0, 0, 1, 1, 1);
    pops = 0;
    repeat (20) step(0, '0, 0, 1, 1, 1);
    check("stream_rate", pops, 20);

    // Credit limit with a stalled consumer, then one pop frees exactly one request.
    step(1, 32'h0000_1000, 0, 1, 0, 1);
    obs_acc = 0;
    repeat (12) step(0, '0, 0, 1, 0, 1);
    check("fill_accepts", obs_acc, DEPTH);
    obs_acc = 0;
    step(0, '0, 0, 1, 1, 1);
    repeat (6) step(0, '0, 0, 1, 0, 1);
    check("refill_accepts", obs_acc, 1);

    // Redirect with three requests in flight.
    step(1, 32'h0000_2000, 0, 1, 1, 0);
    repeat (3) step(0, '0, 0, 1, 1, 0);
    step(1, 32'h0000_0100, 0, 1, 1, 0);
    repeat (10) step(0, '0, 0, 1, 1, 1);

    // Redirect colliding with a response and a pop.
    step(1, 32'h0000_3000, 0, 1, 1, 1);
    repeat (3) step(0, '0, 0, 1, 0, 1);
    step(1, 32'h0000_4000, 0, 1, 1, 1);
    repeat (6) step(0, '0, 0, 1, 1, 1);

    // Halt with two outstanding, drain, then halt together with redirect.
    step(1, 32'h0000_5000, 0, 1, 0, 0);
    repeat (2) step(0, '0, 0, 1, 0, 0);
    step(0, '0, 1, 1, 0, 0);
    repeat (8) step(0, '0, 0, 1, 1, 1);
    step(1, 32'h0000_6000, 1, 1, 1, 1);
    repeat (6) step(0, '0, 0, 1, 1, 1);

    // Address wrap and low-bit masking.
    step(1, 32'hFFFF_FFFC, 0, 1, 1, 1);
    repeat (6) step(0, '0, 0, 1, 1, 1);
    step(1, 32'h0000_0203, 0, 1, 1, 1);
    repeat (6) step(0, '0, 0, 1, 1, 1);

    do_reset();

    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      step($urandom_range(0, 19) == 0, rpc, $urandom_range(0, 14) == 0,
           $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 6);
    end
    repeat (20) step(0, '0, 0, 0, 1, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
